// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: tail of the RISCV32 pipeline.
//   Holds the EX/MEM slot, sequences the data-memory access for loads and
//   stores (lane formatting, wait states, timeout abort, misalignment fault)
//   and holds the MEM/WB write-back record.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   ex_*                  - instruction presented by EX (accepted when ~stall_ex)
//   stall_ex              - EX must hold its instruction this cycle
//   dmem_*                - request/response handshake with data memory
//   rdMem, regWriteMem,
//   aluResultMem          - MEM-slot forwarding information
//   rdWb, regWriteWb,
//   wbData                - write-back record to the register file
//   mem_fault             - one-cycle pulse on misaligned or timed-out access
module mem_wb_pipe #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  output logic        stall_ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rdMem,
  output logic        regWriteMem,
  output logic [31:0] aluResultMem,
  output logic [4:0]  rdWb,
  output logic        regWriteWb,
  output logic [31:0] wbData,
  output logic        mem_fault
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  // MEM slot
  logic        mem_valid_q;
  logic [4:0]  mem_rd_q;
  logic        mem_reg_write_q;   // already qualified with valid
  logic        mem_read_q;
  logic        mem_write_q;
  logic        mem_to_reg_q;
  logic [2:0]  mem_funct3_q;
  logic [31:0] mem_alu_q;
  logic [31:0] mem_sdata_q;

  // Access sequencer
  state_e      state_q;
  logic [7:0]  cnt_q;

  // WB slot
  logic [4:0]  rd_wb_q,  rd_wb_d;
  logic        reg_write_wb_q, reg_write_wb_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        mem_op;
  logic        misaligned;
  logic        abort;

  // Select the addressed lane and extend it according to funct3.
  function automatic logic [31:0] load_fmt(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic [31:0]        lane;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext;
    lane = word >> {off, 3'b000};
    b_s  = lane[7:0];
    h_s  = lane[15:0];
    case (f3)
      3'b000:  ext = 32'(b_s);
      3'b001:  ext = 32'(h_s);
      3'b100:  ext = {24'b0, lane[7:0]};
      3'b101:  ext = {16'b0, lane[15:0]};
      default: ext = lane;
    endcase
    return ext;
  endfunction

  // Byte enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_strb(input logic [1:0] size,
                                            input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store value across lanes so memory only needs the strobe.
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  always_comb begin
    mem_op = mem_valid_q & (mem_read_q | mem_write_q);
    case (mem_funct3_q[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mem_alu_q[0];
      default: misaligned = |mem_alu_q[1:0];
    endcase
    // The slot is held during WAIT, so the request stays up by construction.
    dmem_req  = mem_op & ~misaligned;
    abort     = dmem_req & ~dmem_ready & (state_q == ST_WAIT) & (cnt_q == TMO);
    stall_ex  = dmem_req & ~dmem_ready & ~abort;
    mem_fault = (mem_op & misaligned) | abort;
  end

  assign dmem_we      = mem_write_q;
  assign dmem_addr    = {mem_alu_q[31:2], 2'b00};
  assign dmem_wdata   = store_lanes(mem_funct3_q[1:0], mem_sdata_q);
  assign dmem_wstrb   = mem_write_q ? store_strb(mem_funct3_q[1:0], mem_alu_q[1:0]) : 4'b0000;

  assign rdMem        = mem_rd_q;
  assign regWriteMem  = mem_reg_write_q;
  assign aluResultMem = mem_alu_q;
  assign rdWb         = rd_wb_q;
  assign regWriteWb   = reg_write_wb_q;
  assign wbData       = wb_data_q;

  // MEM -> WB: retire whenever EX is not stalled; a stall sends a bubble
  // that keeps the previous rd and data.
  always_comb begin
    rd_wb_d        = rd_wb_q;
    reg_write_wb_d = 1'b0;
    wb_data_d      = wb_data_q;
    if (!stall_ex) begin
      rd_wb_d        = mem_rd_q;
      reg_write_wb_d = mem_reg_write_q & ~mem_fault;
      wb_data_d      = mem_to_reg_q ? load_fmt(mem_funct3_q, mem_alu_q[1:0], dmem_rdata)
                                    : mem_alu_q;
    end
  end

  // EX -> MEM and MEM -> WB registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= 5'd0;
      mem_reg_write_q <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      mem_funct3_q    <= 3'd0;
      mem_alu_q       <= 32'd0;
      mem_sdata_q     <= 32'd0;
      rd_wb_q         <= 5'd0;
      reg_write_wb_q  <= 1'b0;
      wb_data_q       <= 32'd0;
    end else begin
      if (!stall_ex) begin
        mem_valid_q     <= ex_valid;
        mem_rd_q        <= ex_rd;
        mem_reg_write_q <= ex_valid & ex_reg_write;
        mem_read_q      <= ex_mem_read;
        mem_write_q     <= ex_mem_write;
        mem_to_reg_q    <= ex_mem_to_reg;
        mem_funct3_q    <= ex_funct3;
        mem_alu_q       <= ex_alu_result;
        mem_sdata_q     <= ex_store_data;
      end
      rd_wb_q        <= rd_wb_d;
      reg_write_wb_q <= reg_write_wb_d;
      wb_data_q      <= wb_data_d;
    end
  end

  // Access sequencer: IDLE until a request misses its first cycle, then count
  // wait cycles until ready or timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dmem_req && !dmem_ready) begin
            state_q <= ST_WAIT;
            cnt_q   <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (dmem_ready || abort) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Testbench for mem_wb_pipe (TIMEOUT = 4).
module tb_mem_wb_pipe;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        stall_ex;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [4:0]  rdMem;
  logic        regWriteMem;
  logic [31:0] aluResultMem;
  logic [4:0]  rdWb;
  logic        regWriteWb;
  logic [31:0] wbData;
  logic        mem_fault;

  always #5 clk = ~clk;

  mem_wb_pipe #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_funct3(ex_funct3),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .stall_ex(stall_ex), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .rdMem(rdMem), .regWriteMem(regWriteMem), .aluResultMem(aluResultMem),
    .rdWb(rdWb), .regWriteWb(regWriteWb), .wbData(wbData),
    .mem_fault(mem_fault)
  );

  // Memory responder: ready after wait_ctr wait cycles, never when hold.
  int wait_ctr;
  bit hold;
  always_comb dmem_ready = dmem_req && !hold && (wait_ctr == 0);

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;      // -1: memory never answers
    logic        exp_wr;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    int          exp_stall;
    int          exp_req;
    int          exp_fault;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  vec_t vecs[13];
  wb_t  sbq[$];

  int checks = 0;
  int failures = 0;
  int req_cyc, fault_cyc;
  bit chk_req;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_strb;
  logic        e_we;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle: observe outputs mid-cycle, then advance to next negedge.
  task automatic tick(output logic st);
    logic was_wait;
    wb_t  e;
    #1;
    st = stall_ex;
    if (regWriteWb === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected actual rd=%0d data=0x%08h expected no write", rdWb, wbData);
      end else begin
        e = sbq.pop_front();
        check32("wb_rd", 32'(rdWb), 32'(e.rd));
        check32("wb_data", wbData, e.data);
      end
    end
    if (dmem_req === 1'b1) begin
      req_cyc++;
      if (chk_req) begin
        check32("req_addr", dmem_addr, e_addr);
        check32("req_we", 32'(dmem_we), 32'(e_we));
        if (e_we) begin
          check32("req_wstrb", 32'(dmem_wstrb), 32'(e_strb));
          check32("req_wdata", dmem_wdata, e_wdata);
        end
      end
    end
    if (mem_fault === 1'b1) fault_cyc++;
    was_wait = (dmem_req === 1'b1) && (dmem_ready === 1'b0);
    @(posedge clk);
    #1;
    if (was_wait && wait_ctr > 0) wait_ctr--;
    @(negedge clk);
  endtask

  // Hold the current EX inputs until accepted; return cycles stalled.
  task automatic accept(input string name, output int stalls);
    logic st;
    stalls = 0;
    do begin
      tick(st);
      if (st) stalls++;
    end while (st && stalls < 64);
    if (st) begin
      checks++;
      failures++;
      $display("FAIL %s stall_timeout actual=stalled expected=accepted within 64 cycles", name);
    end
  endtask

  task automatic drive_bubble();
    ex_valid = 1'b0; ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    ex_mem_write = 1'b0; ex_mem_to_reg = 1'b0; ex_funct3 = 3'd0;
    ex_alu_result = 32'd0; ex_store_data = 32'd0;
  endtask

  task automatic drive_vec(input vec_t v);
    ex_valid = v.valid; ex_rd = v.rd; ex_reg_write = v.rw; ex_mem_read = v.mr;
    ex_mem_write = v.mw; ex_mem_to_reg = v.m2r; ex_funct3 = v.f3;
    ex_alu_result = v.addr; ex_store_data = v.sdata;
  endtask

  task automatic check_reset_state(input string tag);
    check32({tag, "_stall_ex"}, 32'(stall_ex), 32'd0);
    check32({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
    check32({tag, "_mem_fault"}, 32'(mem_fault), 32'd0);
    check32({tag, "_rdMem"}, 32'(rdMem), 32'd0);
    check32({tag, "_regWriteMem"}, 32'(regWriteMem), 32'd0);
    check32({tag, "_aluResultMem"}, aluResultMem, 32'd0);
    check32({tag, "_rdWb"}, 32'(rdWb), 32'd0);
    check32({tag, "_regWriteWb"}, 32'(regWriteWb), 32'd0);
    check32({tag, "_wbData"}, wbData, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    s0, s1, sx;
    string n;
    logic  st;
    n = $sformatf("vec%0d", idx);
    dmem_rdata = v.rdata;
    wait_ctr   = (v.waits < 0) ? 0 : v.waits;
    hold       = (v.waits < 0);
    e_addr     = v.addr & 32'hFFFF_FFFC;
    e_we       = v.mw;
    e_strb     = v.exp_strb;
    e_wdata    = v.exp_wdata;
    chk_req    = 1'b1;
    req_cyc    = 0;
    fault_cyc  = 0;
    if (v.exp_wr) sbq.push_back('{rd: v.rd, data: v.exp_data});
    drive_vec(v);
    accept({n, "_issue"}, s0);
    drive_bubble();
    accept({n, "_drain"}, s1);
    tick(st);
    tick(st);
    chk_req = 1'b0;
    hold    = 1'b0;
    sx = s0 + s1;
    check32({n, "_stall_cycles"}, 32'(sx), 32'(v.exp_stall));
    check32({n, "_req_cycles"}, 32'(req_cyc), 32'(v.exp_req));
    check32({n, "_fault_cycles"}, 32'(fault_cyc), 32'(v.exp_fault));
  endtask

  initial begin
    logic st;
    int   s;

    //        valid rd  rw mr mw m2r f3      addr          sdata         rdata        waits wr data          strb     wdata        stl req flt
    vecs[0]  = '{1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,         32'h0,         0, 1'b1, 32'h0000_1234, 4'b0000, 32'h0,         0, 0, 0};
    vecs[1]  = '{1'b1, 5'd6,  1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 0, 1'b1, 32'hFFFF_FF80, 4'b0000, 32'h0,         0, 1, 0};
    vecs[2]  = '{1'b1, 5'd7,  1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 0, 1'b1, 32'h0000_0080, 4'b0000, 32'h0,         0, 1, 0};
    vecs[3]  = '{1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0,         3, 1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF, 3, 4, 0};
    vecs[4]  = '{1'b1, 5'd8,  1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0301, 32'h0,         32'h1111_2222, 0, 1'b0, 32'h0,         4'b0000, 32'h0,         0, 0, 1};
    vecs[5]  = '{1'b1, 5'd9,  1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h0,         32'hDEAD_BEEF, 1, 1'b1, 32'hDEAD_BEEF, 4'b0000, 32'h0,         1, 2, 0};
    vecs[6]  = '{1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0,         32'h80AA_BBCC, 0, 1'b1, 32'hFFFF_80AA, 4'b0000, 32'h0,         0, 1, 0};
    vecs[7]  = '{1'b1, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0100, 32'h0,         32'h80AA_BBCC, 0, 1'b1, 32'h0000_BBCC, 4'b0000, 32'h0,         0, 1, 0};
    vecs[8]  = '{1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0501, 32'h1234_56A5, 32'h0,         2, 1'b0, 32'h0,         4'b0010, 32'hA5A5_A5A5, 2, 3, 0};
    vecs[9]  = '{1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'hCAFE_F00D, 32'h0,         0, 1'b0, 32'h0,         4'b1111, 32'hCAFE_F00D, 0, 1, 0};
    vecs[10] = '{1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0700, 32'h0,         32'h5555_AAAA, -1, 1'b0, 32'h0,        4'b0000, 32'h0,         TMO, TMO + 1, 1};
    vecs[11] = '{1'b1, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0101, 32'h0,         32'h1234_5678, 0, 1'b0, 32'h0,         4'b0000, 32'h0,         0, 0, 1};
    vecs[12] = '{1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'h0,         32'h0,         0, 1'b0, 32'h0,         4'b0000, 32'h0,         0, 0, 0};

    reset = 1'b1;
    hold = 1'b0;
    wait_ctr = 0;
    chk_req = 1'b0;
    dmem_rdata = 32'd0;
    drive_bubble();
    @(negedge clk);
    tick(st);
    tick(st);
    check_reset_state("reset");
    reset = 1'b0;
    tick(st);

    // ALU instruction latency: MEM next cycle, WB the cycle after.
    ex_valid = 1'b1; ex_rd = 5'd5; ex_reg_write = 1'b1; ex_alu_result = 32'h0000_1234;
    sbq.push_back('{rd: 5'd5, data: 32'h0000_1234});
    tick(st);
    check32("add_stall", 32'(st), 32'd0);
    check32("add_rdMem", 32'(rdMem), 32'd5);
    check32("add_regWriteMem", 32'(regWriteMem), 32'd1);
    check32("add_aluResultMem", aluResultMem, 32'h0000_1234);
    check32("add_regWriteWb_early", 32'(regWriteWb), 32'd0);
    drive_bubble();
    tick(st);
    check32("add_rdWb", 32'(rdWb), 32'd5);
    check32("add_regWriteWb", 32'(regWriteWb), 32'd1);
    check32("add_wbData", wbData, 32'h0000_1234);
    tick(st);
    tick(st);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Reset while an access is waiting drops the request on the next cycle.
    hold = 1'b1;
    dmem_rdata = 32'd0;
    drive_vec(vecs[10]);
    ex_alu_result = 32'h0000_0800;
    accept("rstwait_issue", s);
    drive_bubble();
    tick(st);
    check32("rstwait_stall1", 32'(st), 32'd1);
    tick(st);
    check32("rstwait_req_in_wait", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    tick(st);
    check_reset_state("rstwait");
    reset = 1'b0;
    hold = 1'b0;
    tick(st);
    check32("rstwait_req_after", 32'(dmem_req), 32'd0);

    // Full timeout again: counter must restart from zero after the reset.
    run_vec(vecs[10], 10);

    check32("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running expected=finished");
    $fatal(1);
  end

endmodule
